palette_port_arb: RTL and testbench

Arbiter and sequencer for the single-port palette RAM (32 x 8, synchronous read, data one clock after address) in the PPU video path. It shares the RAM between two requesters: the pixel pipeline, which has fixed latency and priority, and the host loader, which uses a valid/ready handshake for palette updates and readback. A bounded-wait counter guarantees the host is never starved during long active-video runs.

---
 rtl/palette_arb_pkg.sv | 20 ++
 rtl/palette_addr_fold.sv | 21 ++
 rtl/palette_port_arb.sv | 143 ++++++++++++++
 tb/tb_palette_port_arb.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/palette_arb_pkg.sv
// Shared types and sizes for the palette RAM arbiter: address/data widths,
// host FSM states and the per-slot pixel pipeline tag.
package palette_arb_pkg;

    localparam int PAL_AW = 5;
    localparam int PAL_DW = 8;

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        RESP
    } host_state_t;

    // valid: a pixel request owned this slot; stolen: the host took it instead
    typedef struct packed {
        logic valid;
        logic stolen;
    } pix_tag_t;

endpackage

// File: rtl/palette_addr_fold.sv
// Combinational palette address fold on the issue path. With PALETTE_MIRROR_EN
// defined, the sprite backdrop entries 0x10/14/18/1C alias to 0x00/04/08/0C.
module palette_addr_fold
    import palette_arb_pkg::*;
(
    input  logic [PAL_AW-1:0] raw,
    output logic [PAL_AW-1:0] folded
);

`ifdef PALETTE_MIRROR_EN
    always_comb begin
        folded = raw;
        if (raw[4] && (raw[1:0] == 2'b00)) begin
            folded[4] = 1'b0;
        end
    end
`else
    assign folded = raw;
`endif

endmodule

// File: rtl/palette_port_arb.sv
// Single-port palette RAM arbiter: fixed-latency pixel lookups have priority,
// host accesses win after MAX_WAIT lost slots. Mirroring via PALETTE_MIRROR_EN.
module palette_port_arb
    import palette_arb_pkg::*;
#(
    parameter int MAX_WAIT = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_req,
    input  logic [PAL_AW-1:0] pix_addr,
    output logic              pix_vld,
    output logic [PAL_DW-1:0] pix_data,
    output logic              pix_stall,
    input  logic              host_valid,
    output logic              host_ready,
    input  logic              host_we,
    input  logic [PAL_AW-1:0] host_addr,
    input  logic [PAL_DW-1:0] host_wdata,
    output logic              host_rvalid,
    output logic [PAL_DW-1:0] host_rdata,
    output logic [PAL_AW-1:0] mem_addr,
    output logic              mem_we,
    output logic [PAL_DW-1:0] mem_wdata,
    input  logic [PAL_DW-1:0] mem_rdata
);

    localparam int WCW = $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

    host_state_t       state;
    logic              hq_we;
    logic [PAL_AW-1:0] hq_addr;
    logic [PAL_DW-1:0] hq_wdata;
    logic [WCW-1:0]    wait_cnt;

    logic              host_issue;
    logic [PAL_AW-1:0] issue_raw;
    logic [PAL_AW-1:0] issue_addr;

    pix_tag_t          tag1, tag2;
    logic              hrd1, hrd2;

    // Host owns the slot when the pixel side is idle or its wait budget is spent
    assign host_issue = (state == PEND) && (!pix_req || (wait_cnt == WAIT_LIMIT));
    assign issue_raw  = host_issue ? hq_addr : pix_addr;

    palette_addr_fold u_fold (
        .raw    (issue_raw),
        .folded (issue_addr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            host_ready <= 1'b1;
            hq_we      <= 1'b0;
            hq_addr    <= '0;
            hq_wdata   <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (host_valid) begin
                        hq_we      <= host_we;
                        hq_addr    <= host_addr;
                        hq_wdata   <= host_wdata;
                        wait_cnt   <= '0;
                        state      <= PEND;
                        host_ready <= 1'b0;
                    end
                end
                PEND: begin
                    if (host_issue) begin
                        if (hq_we) begin
                            state      <= IDLE;
                            host_ready <= 1'b1;
                        end else begin
                            state <= RESP;
                        end
                    end else if (wait_cnt != WAIT_LIMIT) begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                RESP: begin
                    if (hrd2) begin
                        state      <= IDLE;
                        host_ready <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    host_ready <= 1'b1;
                end
            endcase
        end
    end

    // RAM port registers plus the tag pipeline aligned with the one-cycle RAM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr    <= '0;
            mem_we      <= 1'b0;
            mem_wdata   <= '0;
            tag1        <= '0;
            tag2        <= '0;
            hrd1        <= 1'b0;
            hrd2        <= 1'b0;
            pix_vld     <= 1'b0;
            pix_stall   <= 1'b0;
            pix_data    <= '0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
        end else begin
            mem_we <= 1'b0;
            if (host_issue) begin
                mem_addr  <= issue_addr;
                mem_we    <= hq_we;
                mem_wdata <= hq_wdata;
            end else if (pix_req) begin
                mem_addr <= issue_addr;
            end

            tag1.valid  <= pix_req;
            tag1.stolen <= pix_req && host_issue;
            tag2        <= tag1;
            hrd1        <= host_issue && !hq_we;
            hrd2        <= hrd1;

            pix_vld   <= tag2.valid;
            pix_stall <= tag2.valid && tag2.stolen;
            if (tag2.valid && !tag2.stolen) begin
                pix_data <= mem_rdata;
            end

            host_rvalid <= hrd2;
            if (hrd2) begin
                host_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_palette_port_arb.sv
// Directed bench for palette_port_arb (MAX_WAIT = 4) with a 32x8 one-cycle RAM
// model preloaded to addr + 8'h40. Honours PALETTE_MIRROR_EN when defined.
module tb_palette_port_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pix_req;
    logic [4:0] pix_addr;
    logic       pix_vld;
    logic [7:0] pix_data;
    logic       pix_stall;
    logic       host_valid;
    logic       host_ready;
    logic       host_we;
    logic [4:0] host_addr;
    logic [7:0] host_wdata;
    logic       host_rvalid;
    logic [7:0] host_rdata;
    logic [4:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    logic [7:0] ram   [32];
    logic [7:0] model [32];
    logic       preload;

    always #5 clk = ~clk;

    palette_port_arb #(.MAX_WAIT(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_req     (pix_req),
        .pix_addr    (pix_addr),
        .pix_vld     (pix_vld),
        .pix_data    (pix_data),
        .pix_stall   (pix_stall),
        .host_valid  (host_valid),
        .host_ready  (host_ready),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .mem_addr    (mem_addr),
        .mem_we      (mem_we),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) ram[i] <= 8'(i + 'h40);
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    function automatic logic [4:0] fold(input logic [4:0] a);
`ifdef PALETTE_MIRROR_EN
        if (a[4] && (a[1:0] == 2'b00)) return {1'b0, a[3:0]};
`endif
        return a;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [4:0] a, input logic [7:0] d, output logic ok);
        host_valid = 1'b1; host_we = 1'b1; host_addr = a; host_wdata = d;
        tick();
        host_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (host_ready) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic host_read(input logic [4:0] a, output logic [7:0] d, output logic ok);
        host_valid = 1'b1; host_we = 1'b0; host_addr = a;
        tick();
        host_valid = 1'b0;
        ok = 1'b0;
        d  = 8'h00;
        for (int i = 0; i < 20; i++) begin
            if (host_rvalid) begin d = host_rdata; ok = 1'b1; break; end
            tick();
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; preload = 1'b1;
        pix_req = 1'b0; pix_addr = '0;
        host_valid = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        repeat (3) @(posedge clk);
        #1 preload = 1'b0;
        checks++;
        if (host_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL reset_host_ready: got %b expected 1", host_ready);
        end
        checks++;
        if ({pix_vld, pix_stall, host_rvalid, mem_we} !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_strobes: got %b expected 0000", {pix_vld, pix_stall, host_rvalid, mem_we});
        end
        checks++;
        if ({pix_data, host_rdata, mem_addr, mem_wdata} !== 29'd0) begin
            errors++; $display("[TB] FAIL reset_data: got %h expected 0", {pix_data, host_rdata, mem_addr, mem_wdata});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_pixel_stream();
        logic [7:0] exp_d;
        for (int c = 0; c < 36; c++) begin
            pix_req  = (c < 32);
            pix_addr = 5'(c);
            if (c >= 3 && c < 35) begin
                exp_d = model[fold(5'(c - 3))];
                checks++;
                if (pix_vld !== 1'b1 || pix_stall !== 1'b0) begin
                    errors++; $display("[TB] FAIL stream_vld c=%0d: got vld=%b stall=%b expected 1/0", c, pix_vld, pix_stall);
                end
                checks++;
                if (pix_data !== exp_d) begin
                    errors++; $display("[TB] FAIL stream_data c=%0d: got %h expected %h", c, pix_data, exp_d);
                end
            end else begin
                checks++;
                if (pix_vld !== 1'b0) begin
                    errors++; $display("[TB] FAIL stream_idle c=%0d: got vld=%b expected 0", c, pix_vld);
                end
            end
            tick();
        end
        pix_req = 1'b0;
    endtask

    task automatic test_host_write_read();
        checks++;
        if (host_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL hw_ready_idle: got %b expected 1", host_ready);
        end
        host_valid = 1'b1; host_we = 1'b1; host_addr = 5'h05; host_wdata = 8'h1A;
        tick();
        host_valid = 1'b0;
        checks++;
        if (host_ready !== 1'b0) begin
            errors++; $display("[TB] FAIL hw_ready_pend: got %b expected 0", host_ready);
        end
        tick();
        checks++;
        if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 5'h05, 8'h1A}) begin
            errors++; $display("[TB] FAIL hw_issue: got we=%b addr=%h wdata=%h expected 1/05/1a", mem_we, mem_addr, mem_wdata);
        end
        checks++;
        if (host_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL hw_ready_back: got %b expected 1", host_ready);
        end
        model[fold(5'h05)] = 8'h1A;
        host_valid = 1'b1; host_we = 1'b0; host_addr = 5'h05;
        tick();
        host_valid = 1'b0;
        tick();
        checks++;
        if ({mem_we, mem_addr} !== {1'b0, 5'h05}) begin
            errors++; $display("[TB] FAIL hr_issue: got we=%b addr=%h expected 0/05", mem_we, mem_addr);
        end
        tick();
        checks++;
        if (host_rvalid !== 1'b0) begin
            errors++; $display("[TB] FAIL hr_early: got rvalid=%b expected 0", host_rvalid);
        end
        tick();
        checks++;
        if ({host_rvalid, host_rdata, host_ready} !== {1'b1, 8'h1A, 1'b1}) begin
            errors++; $display("[TB] FAIL hr_resp: got rvalid=%b rdata=%h ready=%b expected 1/1a/1", host_rvalid, host_rdata, host_ready);
        end
        tick();
        checks++;
        if (host_rvalid !== 1'b0) begin
            errors++; $display("[TB] FAIL hr_pulse: got rvalid=%b expected 0", host_rvalid);
        end
    endtask

    // Host read of 0x07 under continuous pixel traffic; stolen slot is request 7
    task automatic test_contention();
        logic [7:0] exp_d;
        for (int c = 0; c < 16; c++) begin
            pix_req    = (c < 12);
            pix_addr   = 5'(c + 8);
            host_valid = (c == 2);
            host_we    = 1'b0;
            host_addr  = 5'h07;
            if (c >= 3 && c < 15) begin
                if (c == 10) begin
                    exp_d = model[fold(5'(6 + 8))];
                    checks++;
                    if ({pix_vld, pix_stall, pix_data} !== {1'b1, 1'b1, exp_d}) begin
                        errors++; $display("[TB] FAIL cont_stolen: got vld=%b stall=%b data=%h expected 1/1/%h", pix_vld, pix_stall, pix_data, exp_d);
                    end
                end else begin
                    exp_d = model[fold(5'(c - 3 + 8))];
                    checks++;
                    if ({pix_vld, pix_stall, pix_data} !== {1'b1, 1'b0, exp_d}) begin
                        errors++; $display("[TB] FAIL cont_slot c=%0d: got vld=%b stall=%b data=%h expected 1/0/%h", c, pix_vld, pix_stall, pix_data, exp_d);
                    end
                end
            end
            checks++;
            if (host_rvalid !== (c == 10)) begin
                errors++; $display("[TB] FAIL cont_rvalid c=%0d: got %b expected %b", c, host_rvalid, (c == 10));
            end
            if (c == 10) begin
                checks++;
                if (host_rdata !== 8'h47) begin
                    errors++; $display("[TB] FAIL cont_rdata: got %h expected 47", host_rdata);
                end
            end
            tick();
        end
        pix_req = 1'b0; host_valid = 1'b0;
    endtask

    // Host read of 0x05 slips into the single idle pixel cycle
    task automatic test_gap_issue();
        logic       exp_v;
        logic [7:0] exp_d;
        for (int c = 0; c < 14; c++) begin
            pix_req    = (c < 10) && (c != 4);
            pix_addr   = 5'(c);
            host_valid = (c == 2);
            host_we    = 1'b0;
            host_addr  = 5'h05;
            if (c >= 3) begin
                exp_v = (c - 3 < 10) && (c != 7);
                checks++;
                if ({pix_vld, pix_stall} !== {exp_v, 1'b0}) begin
                    errors++; $display("[TB] FAIL gap_vld c=%0d: got vld=%b stall=%b expected %b/0", c, pix_vld, pix_stall, exp_v);
                end
                if (exp_v) begin
                    exp_d = model[fold(5'(c - 3))];
                    checks++;
                    if (pix_data !== exp_d) begin
                        errors++; $display("[TB] FAIL gap_data c=%0d: got %h expected %h", c, pix_data, exp_d);
                    end
                end
            end
            checks++;
            if (host_rvalid !== (c == 7)) begin
                errors++; $display("[TB] FAIL gap_rvalid c=%0d: got %b expected %b", c, host_rvalid, (c == 7));
            end
            if (c == 7) begin
                checks++;
                if (host_rdata !== 8'h1A) begin
                    errors++; $display("[TB] FAIL gap_rdata: got %h expected 1a", host_rdata);
                end
            end
            tick();
        end
        pix_req = 1'b0; host_valid = 1'b0;
    endtask

    task automatic test_mirror();
        logic       ok;
        logic [7:0] d;
        logic [7:0] exp0;
`ifdef PALETTE_MIRROR_EN
        exp0 = 8'h2C;
`else
        exp0 = 8'h40;
`endif
        host_write(5'h10, 8'h2C, ok);
        model[fold(5'h10)] = 8'h2C;
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("[TB] FAIL mirror_write_done: got %b expected 1", ok);
        end
        host_read(5'h00, d, ok);
        checks++;
        if ({ok, d} !== {1'b1, exp0}) begin
            errors++; $display("[TB] FAIL mirror_read00: got ok=%b data=%h expected 1/%h", ok, d, exp0);
        end
        host_read(5'h10, d, ok);
        checks++;
        if ({ok, d} !== {1'b1, 8'h2C}) begin
            errors++; $display("[TB] FAIL mirror_read10: got ok=%b data=%h expected 1/2c", ok, d);
        end
    endtask

    // Reset lands while a host read sits in RESP and a pixel result is in flight
    task automatic test_reset_pending();
        logic seen;
        pix_req = 1'b1; pix_addr = 5'h03;
        host_valid = 1'b1; host_we = 1'b0; host_addr = 5'h05;
        tick();
        pix_req = 1'b0; host_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({host_ready, pix_vld, pix_stall, host_rvalid, mem_we} !== 5'b10000) begin
            errors++; $display("[TB] FAIL rstp_strobes: got %b expected 10000", {host_ready, pix_vld, pix_stall, host_rvalid, mem_we});
        end
        checks++;
        if ({pix_data, host_rdata, mem_addr, mem_wdata} !== 29'd0) begin
            errors++; $display("[TB] FAIL rstp_data: got %h expected 0", {pix_data, host_rdata, mem_addr, mem_wdata});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen = seen | host_rvalid | pix_vld;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++; $display("[TB] FAIL rstp_dropped: got strobe=%b expected 0", seen);
        end
        checks++;
        if (host_ready !== 1'b1) begin
            errors++; $display("[TB] FAIL rstp_ready: got %b expected 1", host_ready);
        end
        pix_req = 1'b1; pix_addr = 5'h03;
        tick();
        pix_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({pix_vld, pix_stall, pix_data} !== {1'b1, 1'b0, model[fold(5'h03)]}) begin
            errors++; $display("[TB] FAIL rstp_resume: got vld=%b stall=%b data=%h expected 1/0/%h", pix_vld, pix_stall, pix_data, model[fold(5'h03)]);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) model[i] = 8'(i + 'h40);
        test_reset();
        test_pixel_stream();
        test_host_write_read();
        test_contention();
        test_gap_issue();
        test_mirror();
        test_reset_pending();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
